// File: rtl/dc_gen_pkg.sv
// dc_offset_gen shared types and helpers.
// FSM encoding and saturation limits.
package dc_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic longint SAT_MAX(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint SAT_MIN(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// Signed sample + offset with clip to WIDTH.
// Purely combinational; sat flags a clipped result.
module sat_add
  import dc_gen_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int OFS_W = 16
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [OFS_W-1:0] ofs,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  localparam int SW =
    ((WIDTH > OFS_W) ? WIDTH : OFS_W) + 1;
  localparam logic signed [SW-1:0] MAXV =
    SW'(SAT_MAX(WIDTH));
  localparam logic signed [SW-1:0] MINV =
    SW'(SAT_MIN(WIDTH));
  localparam logic [WIDTH-1:0] YMAX = MAXV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] YMIN = MINV[WIDTH-1:0];

  logic signed [SW-1:0] a_x;
  logic signed [SW-1:0] b_x;
  logic signed [SW-1:0] sum;

  assign a_x = {{(SW-WIDTH){sample[WIDTH-1]}}, sample};
  assign b_x = {{(SW-OFS_W){ofs[OFS_W-1]}}, ofs};
  assign sum = a_x + b_x;

  // clip the full-width sum into the output range
  always_comb begin
    y   = sum[WIDTH-1:0];
    sat = 1'b0;
    if (sum > MAXV) begin
      y   = YMAX;
      sat = 1'b1;
    end else if (sum < MINV) begin
      y   = YMIN;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/dc_offset_gen.sv
// Cyclic waveform table player with DC offset.
// Offset steps or ramps; output is saturated.
module dc_offset_gen
  import dc_gen_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter int ADDR_N  = 14,
  parameter int OFS_W   = 16,
  parameter int RAMP_SH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tbl_we,
  input  logic [ADDR_N-1:0] tbl_addr,
  input  logic [WIDTH-1:0]  tbl_data,
  input  logic              start,
  input  logic              stop,
  input  logic [OFS_W-1:0]  ofs_target,
  input  logic              ofs_apply,
  input  logic              ramp_en,
  output logic [WIDTH-1:0]  data_out,
  output logic              valid,
  output logic              sat,
  output logic [15:0]       sat_cnt,
  output logic [OFS_W-1:0]  ofs_cur,
  output logic              busy
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t state;
  state_t state_d;

  logic [WIDTH-1:0]   mem [2**ADDR_N];
  logic [WIDTH-1:0]   rd_q;
  logic [ADDR_N-1:0]  addr;
  logic               v1;
  logic [OFS_W-1:0]   ofs_tgt;
  logic [RAMP_SH-1:0] pre;
  logic [WIDTH-1:0]   sum_y;
  logic               sum_sat;
  logic               run;
  logic               go;
  logic               halt;
  logic               emit;

  assign run  = (state == ST_RUN);
  assign go   = !run && start && !stop;
  assign halt = run && stop;
  assign emit = run && !stop && v1;
  assign busy = run;

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_d;
  end

  // next state: stop has priority over start
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (start && !stop) state_d = ST_RUN;
      ST_RUN:  if (stop)           state_d = ST_IDLE;
    endcase
  end

  // table RAM: loaded only while idle, registered read
  always_ff @(posedge clk) begin
    if (tbl_we && !run) mem[tbl_addr] <= tbl_data;
    rd_q <= mem[addr];
  end

  sat_add #(
    .WIDTH (WIDTH),
    .OFS_W (OFS_W)
  ) u_sat_add (
    .sample (rd_q),
    .ofs    (ofs_cur),
    .y      (sum_y),
    .sat    (sum_sat)
  );

  // address, read-valid and output stage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr     <= '0;
      v1       <= 1'b0;
      data_out <= '0;
      valid    <= 1'b0;
      sat      <= 1'b0;
      sat_cnt  <= '0;
    end else if (go) begin
      addr    <= '0;
      v1      <= 1'b0;
      valid   <= 1'b0;
      sat_cnt <= '0;
    end else if (halt) begin
      v1    <= 1'b0;
      valid <= 1'b0;
    end else if (run) begin
      addr  <= addr + 1'b1;
      v1    <= 1'b1;
      valid <= v1;
      if (v1) begin
        data_out <= sum_y;
        sat      <= sum_sat;
        if (sum_sat && sat_cnt != CNT_MAX)
          sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end

  // offset target latch and step/ramp of applied offset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ofs_tgt <= '0;
      ofs_cur <= '0;
      pre     <= '0;
    end else begin
      if (ofs_apply) ofs_tgt <= ofs_target;
      if (!ramp_en) begin
        ofs_cur <= ofs_tgt;
      end else if (emit) begin
        pre <= pre + 1'b1;
        if (&pre) begin
          if ($signed(ofs_cur) < $signed(ofs_tgt))
            ofs_cur <= ofs_cur + 1'b1;
          else if ($signed(ofs_cur) > $signed(ofs_tgt))
            ofs_cur <= ofs_cur - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dc_offset_gen.sv
// Self-checking bench for dc_offset_gen.
// Vector table, model-checked random runs, corner sequences.
module tb_dc_offset_gen;

  localparam int WIDTH   = 14;
  localparam int ADDR_N  = 4;
  localparam int OFS_W   = 16;
  localparam int RAMP_SH = 2;
  localparam int DEPTH   = 16;

  logic              clk;
  logic              resetn;
  logic              tbl_we;
  logic [ADDR_N-1:0] tbl_addr;
  logic [WIDTH-1:0]  tbl_data;
  logic              start;
  logic              stop;
  logic [OFS_W-1:0]  ofs_target;
  logic              ofs_apply;
  logic              ramp_en;
  logic [WIDTH-1:0]  data_out;
  logic              valid;
  logic              sat;
  logic [15:0]       sat_cnt;
  logic [OFS_W-1:0]  ofs_cur;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int tbl_m [DEPTH];
  int cnt_m;
  int idx_m;

  typedef struct {
    int tv;
    int ofs;
    int exp_d;
    int exp_s;
  } vec_t;

  vec_t vecs [8];

  dc_offset_gen #(
    .WIDTH   (WIDTH),
    .ADDR_N  (ADDR_N),
    .OFS_W   (OFS_W),
    .RAMP_SH (RAMP_SH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .start      (start),
    .stop       (stop),
    .ofs_target (ofs_target),
    .ofs_apply  (ofs_apply),
    .ramp_en    (ramp_en),
    .data_out   (data_out),
    .valid      (valid),
    .sat        (sat),
    .sat_cnt    (sat_cnt),
    .ofs_cur    (ofs_cur),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic int clip(input int s);
    if (s > 8191)  return 8191;
    if (s < -8192) return -8192;
    return s;
  endfunction

  function automatic int sd(input logic [WIDTH-1:0] v);
    int r;
    r = $signed(v);
    return r;
  endfunction

  function automatic int so(input logic [OFS_W-1:0] v);
    int r;
    r = $signed(v);
    return r;
  endfunction

  task automatic fill_tbl(input int v, input bit ramp);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tbl_we   = 1'b1;
      tbl_addr = i[ADDR_N-1:0];
      tbl_data = ramp ? i[WIDTH-1:0] : v[WIDTH-1:0];
      tbl_m[i] = ramp ? i : v;
    end
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic set_ofs(input int v, input logic r);
    @(negedge clk);
    ofs_target = v[OFS_W-1:0];
    ofs_apply  = 1'b1;
    ramp_en    = r;
    @(negedge clk);
    ofs_apply = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_busy", int'(busy), 1);
    chk("lat_v0", int'(valid), 0);
    @(negedge clk);
    chk("lat_v1", int'(valid), 0);
    cnt_m = 0;
    idx_m = 0;
  endtask

  task automatic run_samples(input int n, input int ofs);
    int e;
    int s;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = clip(tbl_m[idx_m % DEPTH] + ofs);
      s = (e != tbl_m[idx_m % DEPTH] + ofs) ? 1 : 0;
      if (s == 1 && cnt_m < 65535) cnt_m++;
      chk("smp_valid", int'(valid), 1);
      chk("smp_data", sd(data_out), e);
      chk("smp_sat", int'(sat), s);
      chk("smp_satcnt", int'(sat_cnt), cnt_m);
      idx_m++;
    end
  endtask

  task automatic stop_run();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_valid", int'(valid), 0);
    chk("stop_busy", int'(busy), 0);
  endtask

  initial begin
    int last;
    int ofs_m;
    int tgt_m;
    int newt;
    int n;
    int r_ofs;
    bit pend;

    resetn = 1'b0; tbl_we = 1'b0; tbl_addr = '0;
    tbl_data = '0; start = 1'b0; stop = 1'b0;
    ofs_target = '0; ofs_apply = 1'b0; ramp_en = 1'b0;

    vecs[0] = '{8000,    500,  8191, 1};
    vecs[1] = '{8000, -20000, -8192, 1};
    vecs[2] = '{100,      50,   150, 0};
    vecs[3] = '{-8192,    -1, -8192, 1};
    vecs[4] = '{8191,      0,  8191, 0};
    vecs[5] = '{-8000, 32767,  8191, 1};
    vecs[6] = '{1000,  -1000,     0, 0};
    vecs[7] = '{-8192,     0, -8192, 0};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", sd(data_out), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_satcnt", int'(sat_cnt), 0);
    chk("rst_ofs", so(ofs_cur), 0);
    resetn = 1'b1;

    // ascending table, wraps with no gap
    fill_tbl(0, 1'b1);
    start_run();
    run_samples(36, 0);
    last = tbl_m[(idx_m - 1) % DEPTH];
    tbl_we   = 1'b1;
    tbl_addr = '0;
    tbl_data = 14'd777;
    stop_run();
    tbl_we = 1'b0;
    chk("stop_hold", sd(data_out), last);

    // start and stop together in IDLE
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ss_busy", int'(busy), 0);
      chk("ss_valid", int'(valid), 0);
      @(negedge clk);
    end

    // offset run, then reset mid-run and replay
    set_ofs(3, 1'b0);
    start_run();
    run_samples(10, 3);
    resetn = 1'b0;
    @(negedge clk);
    chk("mr_busy", int'(busy), 0);
    chk("mr_valid", int'(valid), 0);
    chk("mr_data", sd(data_out), 0);
    chk("mr_satcnt", int'(sat_cnt), 0);
    chk("mr_ofs", so(ofs_cur), 0);
    resetn = 1'b1;
    start_run();
    run_samples(20, 0);
    stop_run();

    // saturation vectors
    for (int v = 0; v < 8; v++) begin
      fill_tbl(vecs[v].tv, 1'b0);
      set_ofs(vecs[v].ofs, 1'b0);
      start_run();
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("vec_valid", int'(valid), 1);
        chk("vec_data", sd(data_out), vecs[v].exp_d);
        chk("vec_sat", int'(sat), vecs[v].exp_s);
        chk("vec_satcnt", int'(sat_cnt),
            vecs[v].exp_s * (k + 1));
      end
      stop_run();
    end

    // random tables and step offsets vs model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        @(negedge clk);
        tbl_m[i] = int'($urandom_range(16383)) - 8192;
        tbl_we   = 1'b1;
        tbl_addr = i[ADDR_N-1:0];
        tbl_data = tbl_m[i][WIDTH-1:0];
      end
      @(negedge clk);
      tbl_we = 1'b0;
      r_ofs = int'($urandom_range(20000)) - 10000;
      set_ofs(r_ofs, 1'b0);
      start_run();
      run_samples(40, r_ofs);
      stop_run();
    end

    // ramp: reset aligns the prescaler
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    fill_tbl(0, 1'b0);
    set_ofs(3, 1'b1);
    start_run();
    ofs_m = 0;
    tgt_m = 3;
    n     = 0;
    pend  = 1'b0;
    newt  = 0;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      chk("rmp_valid", int'(valid), 1);
      chk("rmp_data", sd(data_out), ofs_m);
      n++;
      if (n % 4 == 0) begin
        if (ofs_m < tgt_m) ofs_m++;
        else if (ofs_m > tgt_m) ofs_m--;
      end
      chk("rmp_ofs", so(ofs_cur), ofs_m);
      if (pend) begin
        tgt_m     = newt;
        pend      = 1'b0;
        ofs_apply = 1'b0;
      end
      if (it == 16) begin
        newt       = -1;
        ofs_target = 16'hFFFF;
        ofs_apply  = 1'b1;
        pend       = 1'b1;
      end
    end
    chk("rmp_end", so(ofs_cur), -1);

    // ramp_en dropping jumps straight to target
    ofs_target = 16'd5;
    ofs_apply  = 1'b1;
    @(negedge clk);
    ofs_apply = 1'b0;
    ramp_en   = 1'b0;
    @(negedge clk);
    chk("drop_ofs", so(ofs_cur), 5);
    stop_run();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
